// File: rtl/mem_responder.sv
// mem_responder: single-outstanding request/response memory slave with a
// fixed access latency and DEPTH_WORDS words of 32-bit storage.
//
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   initiator presents a request
//   req_ready   request accepted this cycle (IDLE only)
//   req_we      1 = store, 0 = load
//   req_addr    byte address (word aligned, below DEPTH_WORDS*4)
//   req_wdata   store data
//   resp_valid  response present (RESP state)
//   resp_ready  initiator takes the response
//   resp_rdata  load data, 0 for stores and errors
//   resp_err    request was misaligned or out of range
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request (once the first edge after reset has passed)
// WAIT  | request latched, counting down the access latency
// RESP  | response held until the initiator takes it
//
// Storage is committed (store) or sampled (load) on the edge that enters
// RESP. With LATENCY=0 that edge is the accepting edge itself, so the
// commit path selects the live request instead of the latched copy.
// Storage has no reset; a reset only aborts the transaction in flight.

module mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int          IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  LAT_CNT   = 4'(LATENCY);
   localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              init_q, init_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [31:0]       mem_q [DEPTH_WORDS];

   logic              handshake;
   logic              commit;
   logic              cmt_we;
   logic [31:0]       cmt_addr;
   logic [31:0]       cmt_wdata;
   logic              cmt_err;
   logic [IDX_W-1:0]  widx;
   logic              mem_we;

   // init_q keeps req_ready low until the first edge after reset release
   assign req_ready  = init_q && (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign handshake  = req_valid && req_ready;

   // Commit source: live request on a zero-latency accept, latched copy otherwise
   always_comb begin
      if (state_q == ST_IDLE) begin
         cmt_we    = req_we;
         cmt_addr  = req_addr;
         cmt_wdata = req_wdata;
      end else begin
         cmt_we    = we_q;
         cmt_addr  = addr_q;
         cmt_wdata = wdata_q;
      end
      cmt_err = (cmt_addr[1:0] != 2'b00) || (cmt_addr[31:2] >= DEPTH_LIM);
      widx    = cmt_addr[IDX_W+1:2];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      init_d  = 1'b1;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      commit  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (handshake) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (LAT_CNT == 4'd0) begin
                  state_d = ST_RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = LAT_CNT;
               end
            end
         end
         ST_WAIT: begin
            // Terminal count: RESP is entered one edge after the counter hits 0
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase

      if (commit) begin
         err_d = cmt_err;
         if (cmt_err || cmt_we) begin
            rdata_d = 32'h0;
         end else begin
            rdata_d = mem_q[widx];
         end
      end
   end

   assign mem_we = commit && cmt_we && !cmt_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         init_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         init_q  <= init_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // No reset on storage; commit is impossible while rst_n is low because
   // state_q is forced to IDLE and req_ready is held low.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[widx] <= cmt_wdata;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   localparam int LAT = 2;

   logic        clk;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;

   logic        r0_req_valid, r0_req_ready, r0_req_we;
   logic [31:0] r0_req_addr, r0_req_wdata;
   logic        r0_resp_valid, r0_resp_ready, r0_resp_err;
   logic [31:0] r0_resp_rdata;

   mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   mem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(r0_req_valid), .req_ready(r0_req_ready), .req_we(r0_req_we),
      .req_addr(r0_req_addr), .req_wdata(r0_req_wdata),
      .resp_valid(r0_resp_valid), .resp_ready(r0_resp_ready),
      .resp_rdata(r0_resp_rdata), .resp_err(r0_resp_err)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[16];
   int   pass_cnt = 0;
   int   tot_cnt  = 0;
   int   cyc      = 0;
   int   acc_edge = 0;
   logic valid_prev = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Response scoreboard: pops on every response handshake
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && resp_valid && !valid_prev)
         check("resp_latency", 32'(cyc - acc_edge), 32'(LAT + 1));
      if (resp_valid && resp_ready) begin
         check("resp_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_err", 32'(resp_err), 32'(e.err));
         end
      end
      valid_prev <= resp_valid;
   end

   task automatic wait_ready(output int n);
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("accept_in_time", 32'(n < 20), 32'd1);
      acc_edge = cyc + 1;
   endtask

   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err);
      int   n;
      exp_t e;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      wait_ready(n);
      e.rdata = exp_rd; e.err = exp_err;
      exp_q.push_back(e);
      @(posedge clk); #1;
      // Disturb the request bus after acceptance; only latched values may matter
      req_valid = 1'b0; req_we = ~we; req_addr = addr ^ 32'h4; req_wdata = ~wdata;
      n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("resp_in_time", 32'(n < 30), 32'd1);
      exp_q.delete();
   endtask

   initial begin
      int   n;
      int   last;
      int   acc;
      exp_t e;

      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      int   last;
      int   acc;
      exp_t e;
      logic [31:0] held;

      vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0BAD_C0DE, 32'h0,          1'b0};
      vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          1'b0};
      vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[3]  = '{1'b0, 32'h0000_0013, 32'h0,         32'h0,          1'b1};
      vecs[4]  = '{1'b0, 32'h0000_0400, 32'h0,         32'h0,          1'b1};
      vecs[5]  = '{1'b1, 32'h0000_0100, 32'hCAFE_F00D, 32'h0,          1'b0};
      vecs[6]  = '{1'b1, 32'h0000_0401, 32'h1234_5678, 32'h0,          1'b1};
      vecs[7]  = '{1'b0, 32'h0000_0100, 32'h0,         32'hCAFE_F00D, 1'b0};
      vecs[8]  = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 32'h0,          1'b1};
      vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0BAD_C0DE, 1'b0};
      vecs[10] = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 32'h0,          1'b0};
      vecs[11] = '{1'b0, 32'h0000_03FC, 32'h0,         32'hA5A5_A5A5, 1'b0};
      vecs[12] = '{1'b1, 32'h8000_0010, 32'h9999_9999, 32'h0,          1'b1};
      vecs[13] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[14] = '{1'b1, 32'h0000_0010, 32'h5555_AAAA, 32'h0,          1'b0};
      vecs[15] = '{1'b0, 32'h0000_0010, 32'h0,         32'h5555_AAAA, 1'b0};

      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      resp_ready = 1'b1;
      r0_req_valid = 1'b0; r0_req_we = 1'b0; r0_req_addr = 32'h0; r0_req_wdata = 32'h0;
      r0_resp_ready = 1'b1;

      // Reset values while the clock runs
      #12;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rel_ready_before_edge", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("rel_ready_after_edge", 32'(req_ready), 32'd1);

      for (int i = 0; i < 16; i++)
         txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);

      // Back-pressure: response held for 5 cycles
      resp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
      wait_ready(n);
      e.rdata = 32'h5555_AAAA; e.err = 1'b0;
      exp_q.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = 32'h14;
      n = 0;
      while (resp_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("stall_resp_seen", 32'(n < 20), 32'd1);
      held = resp_rdata;
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 32'(resp_valid), 32'd1);
         check("stall_rdata", resp_rdata, 32'h5555_AAAA);
         check("stall_req_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      check("stall_rdata_stable", resp_rdata, held);
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("stall_ready_after", 32'(req_ready), 32'd1);
      check("stall_queue_empty", 32'(exp_q.size()), 32'd0);
      exp_q.delete();

      // Reset during WAIT of a store aborts it
      txn(1'b1, 32'h20, 32'h1111_1111, 32'h0, 1'b0);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h2222_2222;
      wait_ready(n);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("wait_resp_valid", 32'(resp_valid), 32'd0);
      check("wait_req_ready", 32'(req_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1 check("wrst_resp_valid", 32'(resp_valid), 32'd0);
      check("wrst_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      txn(1'b0, 32'h20, 32'h0, 32'h1111_1111, 1'b0);

      // Reset during RESP drops the response at once
      resp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      wait_ready(n);
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (resp_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rresp_seen", 32'(n < 20), 32'd1);
      check("rresp_rdata", resp_rdata, 32'h0BAD_C0DE);
      #2 rst_n = 1'b0;
      #1 check("rrst_resp_valid", 32'(resp_valid), 32'd0);
      check("rrst_resp_rdata", resp_rdata, 32'h0);
      check("rrst_req_ready", 32'(req_ready), 32'd0);
      resp_ready = 1'b1;
      @(negedge clk);
      check("rrst_hold_valid", 32'(resp_valid), 32'd0);
      check("rrst_hold_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b1;
      #1 check("rrel_ready_before_edge", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("rrel_ready_after_edge", 32'(req_ready), 32'd1);

      // LATENCY=0 instance: response on the accepting edge
      r0_req_valid = 1'b1; r0_req_we = 1'b1; r0_req_addr = 32'h8; r0_req_wdata = 32'h600D_F00D;
      check("l0_ready_idle", 32'(r0_req_ready), 32'd1);
      @(posedge clk); #1;
      r0_req_valid = 1'b0; r0_req_we = 1'b0; r0_req_wdata = 32'h0;
      @(negedge clk);
      check("l0_store_valid", 32'(r0_resp_valid), 32'd1);
      check("l0_store_rdata", r0_resp_rdata, 32'h0);
      check("l0_store_err", 32'(r0_resp_err), 32'd0);
      @(negedge clk);
      r0_req_valid = 1'b1;
      last = -1;
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         if (r0_req_ready === 1'b1) begin
            if (last >= 0) check("l0_accept_gap", 32'(cyc + 1 - last), 32'd2);
            last = cyc + 1;
            acc++;
            check("l0_idle_no_resp", 32'(r0_resp_valid), 32'd0);
         end else begin
            check("l0_resp_valid", 32'(r0_resp_valid), 32'd1);
            check("l0_load_rdata", r0_resp_rdata, 32'h600D_F00D);
         end
         @(negedge clk);
      end
      check("l0_accept_count", 32'(acc), 32'd10);
      r0_req_valid = 1'b0;

      @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
